// File: rtl/spi_seq_pkg.sv
// Shared types and default parameters for the SPI byte sequencer.
package spi_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    typedef logic [7:0] byte_t;

    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_LEN_W      = 8;
    localparam int DEF_TIMEOUT    = 4096;

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
// Push when full and pop when empty are ignored, so callers cannot corrupt state.
module spi_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping; push+pop together keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Multi-byte sequencer in front of a byte-level SPI master.
// TX bytes are buffered and issued one at a time; returned bytes land in an RX FIFO.
// Optional: define SPI_SEQ_TIMEOUT_EN to abort a byte whose spi_done never arrives
// (sticky err, transaction ends with xfer_done). Without it err is tied low.
module spi_byte_sequencer
    import spi_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [7:0]       rx_data,
    input  logic             cmd_start,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             busy,
    output logic             xfer_done,
    output logic             err,
    output logic             spi_start,
    output logic [7:0]       spi_data_in,
    input  logic             spi_done,
    input  logic [7:0]       spi_data_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_t       state;
    logic [LEN_W-1:0] remaining;

    byte_t            tx_head;
    logic             tx_full;
    logic             tx_empty;
    logic [CW-1:0]    tx_count;
    logic             tx_pop;

    logic             rx_full;
    logic             rx_empty;
    logic [CW-1:0]    rx_count;
    logic             rx_push;

    // Issue only with a byte to send and guaranteed room for its reply,
    // so the reply push can never be dropped.
    assign tx_pop   = (state == ISSUE) & ~tx_empty & ~rx_full;
    assign rx_push  = (state == WAIT) & spi_done;
    assign tx_ready = ~tx_full;
    assign rx_valid = ~rx_empty;

    spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_valid),
        .din   (tx_data),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .din   (spi_data_out),
        .pop   (rx_ready),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0] to_cnt;
`else
    assign err = 1'b0;
`endif

    // Transaction FSM; all control outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            busy        <= 1'b0;
            xfer_done   <= 1'b0;
            spi_start   <= 1'b0;
            spi_data_in <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
            to_cnt      <= '0;
            err         <= 1'b0;
`endif
        end else begin
            xfer_done <= 1'b0;
            spi_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        busy      <= 1'b1;
                        remaining <= cmd_len;
                        state     <= (cmd_len != '0) ? ISSUE : FINISH;
                    end
                end
                ISSUE: begin
                    if (tx_pop) begin
                        spi_data_in <= tx_head;
                        spi_start   <= 1'b1;
                        state       <= WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
                        to_cnt      <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (spi_done) begin
                        remaining <= remaining - 1'b1;
                        state     <= (remaining == LEN_W'(1)) ? FINISH : ISSUE;
                    end
`ifdef SPI_SEQ_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= FINISH;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                FINISH: begin
                    xfer_done <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with an echoing SPI master model
// (returns ~byte one cycle after spi_start). Timeout case only when
// SPI_SEQ_TIMEOUT_EN is defined.
module tb_spi_byte_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] rx_data;
    logic       cmd_start;
    logic [7:0] cmd_len;
    logic       busy, xfer_done, err;
    logic       spi_start;
    logic [7:0] spi_data_in;
    logic       spi_done;
    logic [7:0] spi_data_out;

    int vectors    = 0;
    int miscompares = 0;
    int start_cnt  = 0;
    int done_cnt   = 0;
    bit model_en   = 1'b1;
    int stray_req  = 0;
    int stray_ack  = 0;
    int s0, d0;

    always #5 clk = ~clk;

    spi_byte_sequencer #(.FIFO_DEPTH(8), .LEN_W(8), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .cmd_start    (cmd_start),
        .cmd_len      (cmd_len),
        .busy         (busy),
        .xfer_done    (xfer_done),
        .err          (err),
        .spi_start    (spi_start),
        .spi_data_in  (spi_data_in),
        .spi_done     (spi_done),
        .spi_data_out (spi_data_out)
    );

    // Pulse counters
    always @(negedge clk) begin
        if (spi_start === 1'b1) start_cnt++;
        if (xfer_done === 1'b1) done_cnt++;
    end

    // SPI master model: echo inverted byte, done one cycle after start
    initial begin : master
        logic [7:0] b;
        spi_done     = 1'b0;
        spi_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1 && model_en) begin
                b = spi_data_in;
                @(negedge clk);
                spi_done     = 1'b1;
                spi_data_out = ~b;
                @(negedge clk);
                spi_done     = 1'b0;
            end else if (stray_req != stray_ack) begin
                spi_done     = 1'b1;
                spi_data_out = 8'h77;
                @(negedge clk);
                spi_done     = 1'b0;
                stray_ack    = stray_req;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic start(input logic [7:0] len);
        cmd_start = 1'b1;
        cmd_len   = len;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic pop_rx(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, rx_valid, 1);
        chk({tag, "_data"}, rx_data, exp);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_xfer(input string tag, input int max);
        int n = 0;
        while (xfer_done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk(tag, xfer_done, 1);
    endtask

    initial begin : main
        logic [7:0] e;
        rst_n     = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rx_ready  = 1'b0;
        cmd_start = 1'b0;
        cmd_len   = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_xfer_done", xfer_done, 0);
        chk("rst_err", err, 0);
        chk("rst_spi_start", spi_start, 0);
        chk("rst_spi_data_in", spi_data_in, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_ready", tx_ready, 1);

        // Prefilled 3-byte transaction, latency to spi_start
        push(8'hA5); push(8'h3C); push(8'hFF);
        s0 = start_cnt; d0 = done_cnt;
        start(8'd3);
        chk("t1_busy_n1", busy, 1);
        chk("t1_start_n1", spi_start, 0);
        tick();
        chk("t1_start_n2", spi_start, 1);
        chk("t1_data_n2", spi_data_in, 8'hA5);
        wait_xfer("t1_done_seen", 100);
        chk("t1_busy_end", busy, 0);
        tick();
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_start_cnt", start_cnt - s0, 3);
        pop_rx("t1_rx0", 8'h5A);
        pop_rx("t1_rx1", 8'hC3);
        pop_rx("t1_rx2", 8'h00);
        chk("t1_rx_empty", rx_valid, 0);

        // Zero-length command
        s0 = start_cnt; d0 = done_cnt;
        start(8'd0);
        chk("t2_busy", busy, 1);
        chk("t2_done_early", xfer_done, 0);
        tick();
        chk("t2_done", xfer_done, 1);
        chk("t2_busy_end", busy, 0);
        tick();
        chk("t2_start_cnt", start_cnt - s0, 0);
        chk("t2_done_cnt", done_cnt - d0, 1);

        // TX underrun stall then resume
        s0 = start_cnt; d0 = done_cnt;
        push(8'h11); push(8'h22);
        start(8'd4);
        repeat (30) tick();
        chk("t3_stall_starts", start_cnt - s0, 2);
        chk("t3_stall_busy", busy, 1);
        chk("t3_stall_done", done_cnt - d0, 0);
        push(8'h33); push(8'h44);
        wait_xfer("t3_done_seen", 100);
        tick();
        chk("t3_start_cnt", start_cnt - s0, 4);
        pop_rx("t3_rx0", 8'hEE);
        pop_rx("t3_rx1", 8'hDD);
        pop_rx("t3_rx2", 8'hCC);
        pop_rx("t3_rx3", 8'hBB);

        // RX backpressure: 12 bytes, RX depth 8
        s0 = start_cnt; d0 = done_cnt;
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        chk("t4_tx_full", tx_ready, 0);
        start(8'd12);
        repeat (60) tick();
        chk("t4_stall_starts", start_cnt - s0, 8);
        chk("t4_rx_valid", rx_valid, 1);
        chk("t4_tx_ready", tx_ready, 1);
        chk("t4_busy", busy, 1);
        for (int i = 8; i < 12; i++) push(8'h40 + 8'(i));
        repeat (20) tick();
        chk("t4_still_stalled", start_cnt - s0, 8);
        for (int i = 0; i < 12; i++) begin
            int n = 0;
            while (rx_valid !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            e = ~(8'h40 + 8'(i));
            pop_rx($sformatf("t4_rx%0d", i), e);
        end
        repeat (4) tick();
        chk("t4_start_cnt", start_cnt - s0, 12);
        chk("t4_done_cnt", done_cnt - d0, 1);
        chk("t4_busy_end", busy, 0);

        // cmd_start while busy, stray spi_done while idle
        s0 = start_cnt; d0 = done_cnt;
        push(8'h01); push(8'h02);
        start(8'd2);
        tick();
        cmd_start = 1'b1;
        cmd_len   = 8'd5;
        tick();
        cmd_start = 1'b0;
        wait_xfer("t5_done_seen", 100);
        repeat (3) tick();
        chk("t5_start_cnt", start_cnt - s0, 2);
        chk("t5_done_cnt", done_cnt - d0, 1);
        chk("t5_busy", busy, 0);
        pop_rx("t5_rx0", 8'hFE);
        pop_rx("t5_rx1", 8'hFD);
        stray_req++;
        repeat (5) tick();
        chk("t5_stray_rx", rx_valid, 0);
        chk("t5_stray_done", done_cnt - d0, 1);
        chk("t5_stray_start", start_cnt - s0, 2);
        chk("t5_stray_busy", busy, 0);

`ifdef SPI_SEQ_TIMEOUT_EN
        // Master never answers: abort after TIMEOUT cycles
        model_en = 1'b0;
        repeat (2) tick();
        push(8'h09);
        start(8'd1);
        tick();
        chk("t6_spi_start", spi_start, 1);
        repeat (15) tick();
        chk("t6_err_early", err, 0);
        tick();
        chk("t6_err", err, 1);
        chk("t6_done_early", xfer_done, 0);
        tick();
        chk("t6_done", xfer_done, 1);
        repeat (3) tick();
        chk("t6_err_sticky", err, 1);
        chk("t6_busy", busy, 0);
        model_en = 1'b1;
`else
        chk("t6_err_tied", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
